uart_tx_fifo: RTL

Byte buffer and drain controller placed directly upstream of `send_serial`. Producers (CPU store path or a test driver) push bytes at full clock rate. The block queues them and hands them to `send_serial` one at a time using its `we`/`busy` handshake. This replaces the fixed one-shot sender with a continuous, back-pressured byte stream to `uart_rxd_out`.

---
 rtl/uart_tx_fifo.sv | 61 ++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains into send_serial through its we/busy handshake
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   input  logic          ovf_clr,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic [7:0]    tx_data,
   output logic          tx_we,
   input  logic          tx_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;
   state_t        state, state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;
   assign full    = count == FULL_CNT;
   assign empty   = count == '0;
   assign push    = wr_en && !full;
   assign pop     = state == LAUNCH;
   assign tx_we   = pop;
   assign tx_data = pop ? mem[rd_ptr] : 8'h00;
   // byte storage; contents are deliberately left untouched by reset
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
   // pointers, occupancy, sticky overflow (set beats clear) and drain state
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
         if (wr_en && full) overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   // drain sequencing: launch only with data queued and the serializer idle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (!empty && !tx_busy) ? LAUNCH : IDLE;
         LAUNCH:  state_nx = HOLD;
         HOLD:    state_nx = tx_busy ? HOLD : IDLE;
         default: state_nx = IDLE;
      endcase
   end
endmodule
